// File: rtl/awg_sweep_ctrl.sv
// Sweep sequencer for the triangle/DDS generator: steps gen_freq from start to stop
// with a per-point dwell, in single, repeat or up/down modes.
module awg_sweep_ctrl #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [11:0]        cfg_f_start,
    input  logic [11:0]        cfg_f_stop,
    input  logic [11:0]        cfg_f_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [2:0]         cfg_amp,
    input  logic [7:0]         cfg_phase,
    input  logic [1:0]         cfg_mode,
    input  logic [7:0]         cfg_cycles,
    input  logic               start,
    input  logic               abort,
    output logic               gen_en,
    output logic [11:0]        gen_freq,
    output logic [2:0]         gen_amp,
    output logic [7:0]         gen_phase,
    output logic               busy,
    output logic               step_strobe,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state;

    logic [11:0]        c_start, c_stop, c_step;
    logic [DWELL_W-1:0] c_dwell;
    logic [2:0]         c_amp;
    logic [7:0]         c_phase;
    logic [1:0]         c_mode;
    logic [7:0]         c_cycles;

    logic [DWELL_W-1:0] dwell_cnt;
    logic               leg;        // 0: heading to stop, 1: return leg (up/down mode)
    logic [7:0]         sweeps;

    // Step toward tgt, clamping at tgt; the 13-bit sum/difference catches wrap.
    function automatic logic [11:0] toward(input logic [11:0] cur, input logic [11:0] tgt,
                                           input logic [11:0] stp);
        logic [12:0] s;
        logic [11:0] r;
        if (tgt >= cur) begin
            s = {1'b0, cur} + {1'b0, stp};
            r = (s > {1'b0, tgt}) ? tgt : s[11:0];
        end else begin
            s = {1'b0, cur} - {1'b0, stp};
            r = (s[12] || s < {1'b0, tgt}) ? tgt : s[11:0];
        end
        return r;
    endfunction

    logic               cfg_take;
    logic [11:0]        cz_step;
    logic [DWELL_W-1:0] cz_dwell;
    logic [2:0]         cz_amp;
    logic [11:0]        e_start;
    logic [DWELL_W-1:0] e_dwell;
    logic [2:0]         e_amp;
    logic [7:0]         e_phase;

    assign cfg_take = cfg_valid && cfg_ready;
    assign cz_step  = (cfg_f_step == 12'd0) ? 12'd1 : cfg_f_step;
    assign cz_dwell = (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
    assign cz_amp   = (cfg_amp == 3'd0) ? 3'd1 : cfg_amp;
    assign e_start  = cfg_take ? cfg_f_start : c_start;
    assign e_dwell  = cfg_take ? cz_dwell : c_dwell;
    assign e_amp    = cfg_take ? cz_amp : c_amp;
    assign e_phase  = cfg_take ? cfg_phase : c_phase;

    logic [11:0] tgt, nxt_freq;
    logic        at_end, last_sweep, nxt_leg, sweep_end, fin;

    assign tgt        = leg ? c_start : c_stop;
    assign at_end     = (gen_freq == tgt);
    assign last_sweep = (c_cycles != 8'd0) && (sweeps + 8'd1 == c_cycles);

    always_comb begin
        nxt_freq  = toward(gen_freq, tgt, c_step);
        nxt_leg   = leg;
        sweep_end = 1'b0;
        fin       = 1'b0;
        case (c_mode)
            2'b01: if (at_end) begin
                sweep_end = 1'b1;
                nxt_freq  = c_start;
            end
            2'b10: if (at_end) begin
                if (!leg && c_start != c_stop) begin
                    nxt_leg  = 1'b1;
                    nxt_freq = toward(gen_freq, c_start, c_step);
                end else begin
                    // Sweep boundary: skip the repeated f_start point
                    sweep_end = 1'b1;
                    nxt_leg   = 1'b0;
                    nxt_freq  = (c_start == c_stop) ? c_start : toward(c_start, c_stop, c_step);
                end
            end
            default: if (at_end) fin = 1'b1;
        endcase
        if (sweep_end && last_sweep) fin = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            c_start     <= 12'd0;
            c_stop      <= 12'd0;
            c_step      <= 12'd1;
            c_dwell     <= DWELL_W'(1);
            c_amp       <= 3'd1;
            c_phase     <= 8'd0;
            c_mode      <= 2'b00;
            c_cycles    <= 8'd1;
            dwell_cnt   <= '0;
            leg         <= 1'b0;
            sweeps      <= 8'd0;
            cfg_ready   <= 1'b0;
            gen_en      <= 1'b0;
            gen_freq    <= 12'd0;
            gen_amp     <= 3'd1;
            gen_phase   <= 8'd0;
            busy        <= 1'b0;
            step_strobe <= 1'b0;
            done        <= 1'b0;
        end else begin
            step_strobe <= 1'b0;
            done        <= 1'b0;
            if (cfg_take) begin
                c_start  <= cfg_f_start;
                c_stop   <= cfg_f_stop;
                c_step   <= cz_step;
                c_dwell  <= cz_dwell;
                c_amp    <= cz_amp;
                c_phase  <= cfg_phase;
                c_mode   <= cfg_mode;
                c_cycles <= cfg_cycles;
            end
            if (abort) begin
                state     <= IDLE;
                gen_en    <= 1'b0;
                busy      <= 1'b0;
                cfg_ready <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        cfg_ready <= 1'b1;
                        if (start) begin
                            state       <= RUN;
                            gen_freq    <= e_start;
                            gen_amp     <= e_amp;
                            gen_phase   <= e_phase;
                            gen_en      <= 1'b1;
                            busy        <= 1'b1;
                            step_strobe <= 1'b1;
                            cfg_ready   <= 1'b0;
                            dwell_cnt   <= e_dwell;
                            leg         <= 1'b0;
                            sweeps      <= 8'd0;
                        end
                    end
                    RUN: begin
                        if (dwell_cnt > DWELL_W'(1)) begin
                            dwell_cnt <= dwell_cnt - DWELL_W'(1);
                        end else if (fin) begin
                            state  <= FIN;
                            done   <= 1'b1;
                            gen_en <= 1'b0;
                        end else begin
                            gen_freq    <= nxt_freq;
                            leg         <= nxt_leg;
                            dwell_cnt   <= c_dwell;
                            step_strobe <= 1'b1;
                            if (sweep_end) sweeps <= sweeps + 8'd1;
                        end
                    end
                    FIN: begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/awg_sweep_ctrl.md
# awg_sweep_ctrl

Sequencing controller for the triangle/DDS waveform generator. It holds a sweep configuration and drives the generator's `en`, `freq`, `amp` and `phase` inputs. It steps frequency from a start value to a stop value, with a programmable dwell per point, in single, repeat or up/down modes. It sits between the host/register side and the generator, and is the only writer of the generator's control inputs.

## Interface
Parameters:
- DWELL_W, 16, width of the dwell counter and `cfg_dwell`

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  configuration offer
- cfg_ready  out  1  high only in IDLE and not in reset
- cfg_f_start  in  12  first sweep frequency word
- cfg_f_stop  in  12  end sweep frequency word
- cfg_f_step  in  12  step magnitude (0 is treated as 1)
- cfg_dwell  in  DWELL_W  cycles held per point (0 is treated as 1)
- cfg_amp  in  3  amplitude divisor (0 is coerced to 1)
- cfg_phase  in  8  channel-B phase offset
- cfg_mode  in  2  00 single, 01 repeat, 10 up/down, 11 same as 00
- cfg_cycles  in  8  sweep count for modes 01/10; 0 means run until abort
- start  in  1  launch pulse; honoured only in IDLE
- abort  in  1  stop immediately
- gen_en  out  1  generator enable
- gen_freq  out  12  generator frequency word
- gen_amp  out  3  generator amplitude, never 0
- gen_phase  out  8  generator phase offset
- busy  out  1  high in any state other than IDLE
- step_strobe  out  1  1-cycle pulse in the cycle a new `gen_freq` first appears
- done  out  1  1-cycle pulse on normal completion

## Operation
- States: IDLE, RUN (dwell counting), DONE (1 cycle). All outputs are registered.
- Config capture: when `cfg_valid && cfg_ready`, all `cfg_*` fields are latched, with `cfg_amp`, `cfg_f_step` and `cfg_dwell` coerced as listed above. While busy, `cfg_valid` has no effect.
- Direction: up if `f_start <= f_stop`, otherwise down.
- Next point: computed in 13 bits as `cur ± step`. If the result passes `f_stop` (or `f_start` on the return leg), or over/underflows 12 bits, it is clamped to that endpoint. The frequency word never wraps.
- Mode 00: visits points f_start … f_stop, then goes to DONE.
- Mode 01: after dwelling at f_stop, restarts at f_start.
- Mode 10: one sweep is the up leg followed by the down leg, ending at f_start. Endpoints are not repeated at turnarounds or at sweep boundaries.
- Sweep count: completing sweep number `cfg_cycles` goes to DONE. With a count of 0, the block runs until abort.
- Mode 00 ignores `cfg_cycles`.
- IDLE→RUN on `start`: `gen_freq`=f_start, `gen_amp`/`gen_phase` from config, `gen_en`=1.
- RUN→DONE after the last point's dwell expires. In DONE, `done`=1 and `gen_en`=0, then the block returns to IDLE.
- `abort` in any state: next cycle the block is in IDLE with `gen_en`=0 and `busy`=0. No `done` pulse is generated. `gen_freq` holds its value.
- `start` and config handshake in the same cycle: the start uses the newly offered config.
- `start` together with `abort`: `abort` wins and the block stays in IDLE.

## Timing
- Reset values:
  - `gen_en`=0, `gen_freq`=0, `gen_amp`=1, `gen_phase`=0.
  - `busy`=0, `step_strobe`=0, `done`=0, `cfg_ready`=0 during reset.
  - Latched config: start=stop=0, step=1, dwell=1, amp=1, mode=00, cycles=1.
- Start latency: `start` sampled in cycle 0 → `gen_en`, `busy` and `step_strobe` are high in cycle 1.
- Dwell: each point's value is present for exactly `dwell` cycles. The next value appears the cycle after, with `step_strobe` high.
- Completion: `done` is high in the cycle immediately after the final point's last dwell cycle. `gen_en` is low in that same cycle.
- Reset mid-run: all registers return to their reset values on the next edge.

## Test plan
- Basic single sweep: f_start=100, f_stop=130, step=10, dwell=4, mode 00, `start` at cycle 0.
  - `gen_freq` is 100/110/120/130 for 4 cycles each over cycles 1–16.
  - `step_strobe` pulses at cycles 1, 5, 9, 13.
  - `done` pulses at cycle 17 with `gen_en`=0.
- Clamping:
  - Start 100, stop 125, step 10 → 100, 110, 120, 125.
  - Start 4090, stop 4095, step 4000 → 4090, 4095 (no wrap).
  - Start 50, stop 20, step 20 → 50, 30, 20.
- Up/down with count: mode 10, cycles=2, start 0, stop 20, step 10, dwell 1 → 0, 10, 20, 10, 0, 10, 20, 10, 0, then `done`.
- Abort mid-dwell: mode 01, cycles=0, `abort` at cycle 7 → `gen_en`=0 and `busy`=0 at cycle 8, no `done`, `cfg_ready`=1 at cycle 8.
- Config rules:
  - `cfg_amp`=0, `cfg_dwell`=0, `cfg_f_step`=0 → `gen_amp`=1, each point held 1 cycle, step of 1.
  - `cfg_valid` while busy → `cfg_ready`=0 and the running sweep is unchanged.
- Reset mid-run: `rst` at cycle 5 of a run → all outputs at their reset values from cycle 6. A later `start` uses the reset-default config (single point at 0, held 1 cycle, then `done`).
